// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: default sizes, the
// write-request record and the one-hot register-select decoder.
package regfile_pkg;

   localparam int DW_DEFAULT    = 16;
   localparam int NREG_DEFAULT  = 8;
   localparam int AW_DEFAULT    = (NREG_DEFAULT > 1) ? $clog2(NREG_DEFAULT) : 1;
   localparam int DEPTH_DEFAULT = 4;

   // One write request at the default sizes.
   typedef struct packed {
      logic [AW_DEFAULT-1:0] addr;
      logic [DW_DEFAULT-1:0] data;
   } wr_req_t;

   // One-hot select of register idx among n registers (n <= 64). An index at
   // or beyond n selects nothing, so such a write is dropped. Callers keep the
   // low n bits of the result.
   function automatic logic [63:0] onehot_dec(input logic [31:0] idx, input int unsigned n);
      logic [63:0] sel;
      sel = '0;
      if ((idx < n) && (idx < 32'd64)) begin
         sel[idx[5:0]] = 1'b1;
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Write-request handshake and register-drive bus of the register-file write
// front end. The requester uses the master modport, the controller the slave.
interface regfile_write_ctrl_if #(
   parameter int DW    = 16,
   parameter int NREG  = 8,
   parameter int DEPTH = 4
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          hold;
   logic [DW-1:0] sin;
   logic [NREG-1:0] ce;
   logic          busy;
   logic [CW-1:0] count;

   modport master (
      output wr_valid, wr_addr, wr_data, hold,
      input  wr_ready, sin, ce, busy, count
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, hold,
      output wr_ready, sin, ce, busy, count
   );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO holding pending register writes. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module regfile_wr_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
   assign count   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[PW-2:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Advance pointers on accepted push/pop; wrap is natural modulo 2*DEPTH.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Store the incoming request at the write slot.
   // NOTE: storage is deliberately not reset; only the pointers decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-2:0]] <= wdata;
   end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port front end of the register file: accepts valid/ready requests,
// queues them, and drains one per cycle as a data bus plus a one-hot
// clock-enable pulse. Optional build macro REGFILE_R0_ZERO_EN makes
// register 0 read-only zero (its ce bit is never asserted).
module regfile_write_ctrl
   import regfile_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int NREG  = NREG_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_write_ctrl_if.slave bus
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   req_t            push_req;
   req_t            head;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic [CW-1:0]   fifo_count;
   logic [63:0]     dec_full;
   logic [NREG-1:0] ce_d;
   logic [NREG-1:0] ce_q;
   logic [DW-1:0]   sin_q;

   // Ready depends on registered occupancy only, never on wr_valid.
   assign bus.wr_ready = !full;
   assign push         = bus.wr_valid && !full;
   assign pop          = !empty && !bus.hold;
   assign push_req     = '{addr: bus.wr_addr, data: bus.wr_data};

   regfile_wr_fifo #(
      .WIDTH ($bits(req_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_req),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Decode the head entry's address into the register clock-enable pattern.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      dec_full = onehot_dec(32'(head.addr), NREG);
      ce_d     = dec_full[NREG-1:0];
`ifdef REGFILE_R0_ZERO_EN
      ce_d[0]  = 1'b0;
`else
`endif
   end

   // Drive the bus on each pop; ce is a one-cycle pulse, sin holds between pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_q  <= '0;
         sin_q <= '0;
      end else if (pop) begin
         ce_q  <= ce_d;
         sin_q <= head.data;
      end else begin
         ce_q  <= '0;
      end
   end

   assign bus.ce    = ce_q;
   assign bus.sin   = sin_q;
   assign bus.count = fifo_count;
   assign bus.busy  = !empty || (|ce_q);

endmodule
